// File: rtl/tankb_scandoubler.sv
// Line-doubling scan converter: each 15.6 kHz source line is captured into one bank of a
// ping-pong buffer while the other bank is replayed twice at double pixel rate.
module tankb_scandoubler #(
    parameter int ADDR_W = 9,
    parameter int RGB_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_ce,
    input  logic             pix2_ce,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic             hs_in_n,
    input  logic             vs_in_n,
    output logic [RGB_W-1:0] rgb_out,
    output logic             hs_out_n,
    output logic             vs_out_n,
    output logic             line_valid
);

    localparam logic [ADDR_W-1:0] X_MAX = '1;
    localparam logic [ADDR_W-1:0] X_ONE = ADDR_W'(1);

    logic [RGB_W-1:0]  line_mem [2**(ADDR_W+1)];

    logic [ADDR_W-1:0] in_x;
    logic [ADDR_W-1:0] in_len;
    logic [ADDR_W-1:0] out_x;
    logic [ADDR_W-1:0] out_x_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        hs_cnt;
    logic [7:0]        hs_len;
    logic              wr_bank;
    logic              wr_sel;
    logic              rd_bank;
    logic              hs_prev;
    logic              seen_fall;
    logic              resync;
    logic              vs_smp;
    logic              vs_line;
    logic              hs_fall;
    logic              hs_rise;
    logic              wrap;

    logic [RGB_W-1:0]  rd_data_p1;
    logic              hs_p1;
    logic              vs_p1;
    logic              blank_p1;

    assign hs_fall = hs_prev & ~hs_in_n;
    assign hs_rise = ~hs_prev & hs_in_n;

    // The sample carrying the hsync falling edge is pixel 0 of the new line, so a line of
    // N pix_ce periods measures in_len = N and its hsync occupies x = 0 .. hs_len-1.
    assign wr_sel  = hs_fall ? ~wr_bank : wr_bank;
    assign wr_addr = hs_fall ? '0 : in_x;

    always_ff @(posedge clk) begin
        if (pix_ce) begin
            line_mem[{wr_sel, wr_addr}] <= rgb_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_x       <= '0;
            in_len     <= '0;
            wr_bank    <= 1'b0;
            hs_prev    <= 1'b1;
            hs_cnt     <= '0;
            hs_len     <= '0;
            seen_fall  <= 1'b0;
            line_valid <= 1'b0;
            vs_smp     <= 1'b1;
        end else if (pix_ce) begin
            hs_prev <= hs_in_n;
            vs_smp  <= vs_in_n;
            if (hs_fall) begin
                in_len    <= in_x;
                in_x      <= X_ONE;
                wr_bank   <= ~wr_bank;
                seen_fall <= 1'b1;
                if (seen_fall && (in_x != '0)) begin
                    line_valid <= 1'b1;
                end
            end else if (in_x != X_MAX) begin
                in_x <= in_x + X_ONE;
            end
            if (!hs_in_n) begin
                if (hs_cnt != 8'hFF) begin
                    hs_cnt <= hs_cnt + 8'd1;
                end
            end else if (hs_rise) begin
                hs_len <= hs_cnt;
                hs_cnt <= '0;
            end
        end
    end

    // Resync request survives until the first pix2_ce strictly after the falling-edge sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resync <= 1'b0;
        end else if (pix_ce && hs_fall) begin
            resync <= 1'b1;
        end else if (pix2_ce) begin
            resync <= 1'b0;
        end
    end

    assign wrap      = (in_len == '0) ? (out_x == X_MAX) : (out_x == in_len - X_ONE);
    assign out_x_nxt = (resync || wrap) ? '0 : out_x + X_ONE;

    // Read bank and vsync are latched at every output line start so a bank swap can never
    // tear an output line in the middle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_x   <= '0;
            rd_bank <= 1'b1;
            vs_line <= 1'b1;
        end else if (pix2_ce) begin
            out_x <= out_x_nxt;
            if (out_x_nxt == '0) begin
                rd_bank <= ~wr_bank;
                vs_line <= vs_smp;
            end
        end
    end

    // Stage p1: synchronous buffer read alongside sync/blank decode.
    always_ff @(posedge clk) begin
        rd_data_p1 <= line_mem[{rd_bank, out_x}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p1    <= 1'b0;
            vs_p1    <= 1'b1;
            blank_p1 <= 1'b1;
        end else begin
            hs_p1    <= 32'(out_x) < 32'(hs_len);
            vs_p1    <= vs_line;
            blank_p1 <= (32'(out_x) < 32'(hs_len)) | ~line_valid;
        end
    end

    // Stage p2: registered VGA pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out  <= '0;
            hs_out_n <= 1'b1;
            vs_out_n <= 1'b1;
        end else begin
            rgb_out  <= blank_p1 ? '0 : rd_data_p1;
            hs_out_n <= ~hs_p1;
            vs_out_n <= vs_p1;
        end
    end

endmodule
